// File: rtl/steer_arb_if.sv
// Steering arbiter bus: sensor/command inputs and the error/speed outputs to the PID.
// The master modport drives the inputs; the slave modport is the arbiter side.
interface steer_arb_if;
  logic        go;
  logic        line_present;
  logic        err_vld;
  logic [15:0] err_line;
  logic [15:0] err_opn_lp;
  logic [15:0] err;
  logic        err_out_vld;
  logic [10:0] frwrd;
  logic        moving;
  logic        src_open;

  modport master (
    output go, line_present, err_vld, err_line, err_opn_lp,
    input  err, err_out_vld, frwrd, moving, src_open
  );

  modport slave (
    input  go, line_present, err_vld, err_line, err_opn_lp,
    output err, err_out_vld, frwrd, moving, src_open
  );
endinterface

// File: rtl/steer_arb.sv
// Steering-error source arbiter and forward-speed sequencer, stepped once per err_vld.
// Optional STEER_ARB_FILT_EN adds a 4-tap moving average on err_line.
module steer_arb #(
  parameter logic [10:0] RAMP_STEP = 11'd16,
  parameter logic [10:0] MAX_FRWRD = 11'h2A0,
  parameter int unsigned LOST_CNT  = 4,
  parameter int unsigned FND_CNT   = 3,
  parameter logic [15:0] ERR_SAT   = 16'h07FF
) (
  input  logic       clk,
  input  logic       rst_n,
  steer_arb_if.slave bus
);

  localparam int unsigned CNT_MAX = (LOST_CNT > FND_CNT) ? LOST_CNT : FND_CNT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LOST_LAST  = CW'(LOST_CNT - 1);
  localparam logic [CW-1:0] FND_LAST   = CW'(FND_CNT - 1);
  localparam logic [10:0]   HALF_FRWRD = MAX_FRWRD >> 1;
  localparam logic [11:0]   DEC_STEP   = {RAMP_STEP, 1'b0};

  typedef enum logic [2:0] {
    ST_STOP,
    ST_RAMP,
    ST_LINE,
    ST_OPEN,
    ST_DECEL
  } state_e;

  state_e        state_q, state_d, cur_st;
  logic [15:0]   err_q, err_d;
  logic [10:0]   frwrd_q, frwrd_d;
  logic          err_out_vld_q;
  logic          moving_q;
  logic          src_open_q;
  logic [CW-1:0] lost_q, lost_d;
  logic [CW-1:0] fnd_q, fnd_d;
  logic [11:0]   up12, dn12;
  logic [15:0]   line_val;

  function automatic logic [15:0] sat(input logic [15:0] x);
    logic signed [15:0] xs, hi, lo;
    xs = $signed(x);
    hi = $signed(ERR_SAT);
    lo = -hi;
    if (xs > hi) begin
      sat = $unsigned(hi);
    end else if (xs < lo) begin
      sat = $unsigned(lo);
    end else begin
      sat = x;
    end
  endfunction

`ifdef STEER_ARB_FILT_EN
  logic [15:0] hist0_q, hist1_q, hist2_q;
  logic [17:0] fsum;
  logic        hist_clr;

  // History restarts when tracking resumes after an open-loop stretch.
  assign hist_clr = (state_q == ST_OPEN) && (state_d == ST_RAMP);

  always_comb begin
    fsum = {{2{bus.err_line[15]}}, bus.err_line}
         + {{2{hist0_q[15]}}, hist0_q}
         + {{2{hist1_q[15]}}, hist1_q}
         + {{2{hist2_q[15]}}, hist2_q};
    line_val = fsum[17:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist0_q <= '0;
      hist1_q <= '0;
      hist2_q <= '0;
    end else if (bus.err_vld) begin
      if (hist_clr) begin
        hist0_q <= '0;
        hist1_q <= '0;
        hist2_q <= '0;
      end else begin
        hist0_q <= bus.err_line;
        hist1_q <= hist0_q;
        hist2_q <= hist1_q;
      end
    end
  end
`else
  assign line_val = bus.err_line;
`endif

  // go-level redirects act every cycle so the sample that follows already
  // runs in the redirected state (DECEL always wins).
  always_comb begin
    cur_st = state_q;
    if ((state_q != ST_STOP) && !bus.go) begin
      cur_st = ST_DECEL;
    end else if ((state_q == ST_STOP) && bus.go && bus.line_present) begin
      cur_st = ST_RAMP;
    end else if ((state_q == ST_DECEL) && bus.go) begin
      cur_st = ST_RAMP;
    end
  end

  always_comb begin
    state_d = cur_st;
    frwrd_d = frwrd_q;
    err_d   = err_q;
    lost_d  = lost_q;
    fnd_d   = fnd_q;
    up12    = '0;
    dn12    = '0;

    if (bus.err_vld) begin
      unique case (cur_st)
        ST_STOP: begin
          frwrd_d = '0;
        end
        ST_RAMP, ST_LINE: begin
          if (cur_st == ST_RAMP) begin
            up12 = {1'b0, frwrd_q} + {1'b0, RAMP_STEP};
            frwrd_d = (up12 >= {1'b0, MAX_FRWRD}) ? MAX_FRWRD : up12[10:0];
          end else begin
            frwrd_d = MAX_FRWRD;
          end
          // Reaching cruise outranks a coincident lost threshold.
          if ((cur_st == ST_RAMP) && (frwrd_d == MAX_FRWRD)) begin
            state_d = ST_LINE;
          end else if (!bus.line_present) begin
            if (lost_q == LOST_LAST) begin
              state_d = ST_OPEN;
            end else begin
              lost_d = lost_q + CW'(1);
            end
          end else begin
            lost_d = '0;
          end
        end
        ST_OPEN: begin
          if (frwrd_q > HALF_FRWRD) begin
            dn12 = {1'b0, frwrd_q} - {1'b0, RAMP_STEP};
            if ({1'b0, frwrd_q} >= ({1'b0, HALF_FRWRD} + {1'b0, RAMP_STEP})) begin
              frwrd_d = dn12[10:0];
            end else begin
              frwrd_d = HALF_FRWRD;
            end
          end
          if (bus.line_present) begin
            if (fnd_q == FND_LAST) begin
              state_d = ST_RAMP;
            end else begin
              fnd_d = fnd_q + CW'(1);
            end
          end else begin
            fnd_d = '0;
          end
        end
        ST_DECEL: begin
          dn12 = {1'b0, frwrd_q} - DEC_STEP;
          frwrd_d = ({1'b0, frwrd_q} > DEC_STEP) ? dn12[10:0] : '0;
          if (frwrd_d == '0) begin
            state_d = ST_STOP;
          end
        end
        default: begin
          state_d = ST_STOP;
          frwrd_d = '0;
        end
      endcase

      // The error source follows the state this sample lands in.
      unique case (state_d)
        ST_RAMP, ST_LINE: err_d = sat(line_val);
        ST_OPEN:          err_d = sat(bus.err_opn_lp);
        default:          err_d = '0;
      endcase
    end

    if (state_d != state_q) begin
      lost_d = '0;
      fnd_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_STOP;
      err_q         <= '0;
      frwrd_q       <= '0;
      err_out_vld_q <= 1'b0;
      moving_q      <= 1'b0;
      src_open_q    <= 1'b0;
      lost_q        <= '0;
      fnd_q         <= '0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      frwrd_q       <= frwrd_d;
      err_out_vld_q <= bus.err_vld;
      moving_q      <= (frwrd_d != '0);
      src_open_q    <= (state_d == ST_OPEN);
      lost_q        <= lost_d;
      fnd_q         <= fnd_d;
    end
  end

  assign bus.err         = err_q;
  assign bus.err_out_vld = err_out_vld_q;
  assign bus.frwrd       = frwrd_q;
  assign bus.moving      = moving_q;
  assign bus.src_open    = src_open_q;

endmodule
